// File: rtl/ysyx_23060184_inst_queue_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_inst_queue_pkg
//   Shared constants for the fetch/decode instruction queue.
//   - IQ_DATA_WIDTH  : width of PC and instruction words
//   - IQ_ACERR_WIDTH : width of the fetch bus response code
//   - RESP_OKAY      : response encoding meaning "no access fault"
//   - INST_NOP       : addi x0,x0,0, substituted for faulted fetches
// ---------------------------------------------------------------------------
package ysyx_23060184_inst_queue_pkg;

  localparam int          IQ_DATA_WIDTH  = 32;
  localparam int          IQ_ACERR_WIDTH = 2;
  localparam int          RESP_OKAY      = 0;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060184_inst_queue.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_inst_queue
//   Circular-buffer FIFO between fetch and decode. Each entry holds
//   {pc, inst, fault}. A flush discards all entries in one cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               redirect: drop every buffered entry
//   in_valid/in_ready   fetch-side handshake
//   in_pc/in_inst       fetched word and its PC
//   in_resp             bus response, nonzero = access fault
//   out_valid/out_ready decode-side handshake
//   out_pc/out_pcplus4  head PC and PC+4
//   out_inst            head instruction, NOP when faulted
//   out_fault           head entry carried an access fault
//   count               current occupancy
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1 and flush is 0. valid never depends on ready on either side;
// in_ready and out_valid are functions of registered state only.
// ---------------------------------------------------------------------------
module ysyx_23060184_inst_queue
  import ysyx_23060184_inst_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = IQ_DATA_WIDTH,
  parameter int ACERR_WIDTH = IQ_ACERR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_inst,
  input  logic [ACERR_WIDTH-1:0]   in_resp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_pcplus4,
  output logic [DATA_WIDTH-1:0]    out_inst,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;

  logic [DATA_WIDTH-1:0] r_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_inst [DEPTH];
  logic                  r_fault[DEPTH];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_ridx;
  logic [AW-1:0]         w_widx;

  assign w_ridx  = r_rptr[AW-1:0];
  assign w_widx  = r_wptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;

  assign w_push = in_valid  && !w_full  && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Pointer difference is the occupancy; the wrap bit makes it exact.
  assign count = r_wptr - r_rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      // Discard by catching the read pointer up; storage is untouched.
      r_rptr <= r_wptr;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset: it is only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[w_widx]    <= in_pc;
      r_inst[w_widx]  <= in_inst;
      r_fault[w_widx] <= (in_resp != ACERR_WIDTH'(RESP_OKAY));
    end
  end

  assign out_pc      = r_pc[w_ridx];
  assign out_pcplus4 = r_pc[w_ridx] + DATA_WIDTH'(4);
  // Gated with !empty so the fault flag reads 0 out of reset.
  assign out_fault   = r_fault[w_ridx] && !w_empty;
  assign out_inst    = r_fault[w_ridx] ? DATA_WIDTH'(INST_NOP) : r_inst[w_ridx];

endmodule

// File: tb/tb_ysyx_23060184_inst_queue.sv
module tb_ysyx_23060184_inst_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 2;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic          fault;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_inst;
  logic [AW-1:0] in_resp;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_pcplus4;
  logic [DW-1:0] out_inst;
  logic          out_fault;
  logic [2:0]    count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ysyx_23060184_inst_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .ACERR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_resp(in_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4),
    .out_inst(out_inst), .out_fault(out_fault),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  entry_t exp_q[$];
  int     tests_run;
  int     tests_failed;

  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all visible outputs against the queue model.
  task automatic check_outputs(input string tag);
    check_val({tag, ".count"},     DW'(count),     DW'(exp_q.size()));
    check_val({tag, ".out_valid"}, DW'(out_valid), DW'(exp_q.size() != 0));
    check_val({tag, ".in_ready"},  DW'(in_ready),  DW'(exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      check_val({tag, ".out_pc"},      out_pc,         exp_q[0].pc);
      check_val({tag, ".out_pcplus4"}, out_pcplus4,    exp_q[0].pc + 32'd4);
      check_val({tag, ".out_inst"},    out_inst,
                exp_q[0].fault ? 32'h0000_0013 : exp_q[0].inst);
      check_val({tag, ".out_fault"},   DW'(out_fault), DW'(exp_q[0].fault));
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive inputs, check state, model the edge, advance.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] pc,
                       input logic [DW-1:0] inst, input logic [AW-1:0] resp,
                       input logic ordy, input logic fl);
    bit     do_push;
    bit     do_pop;
    entry_t e;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_resp   = resp;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(tag);
    do_push = v && (exp_q.size() < DEPTH) && !fl;
    do_pop  = ordy && (exp_q.size() != 0) && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        e.pc    = pc;
        e.inst  = inst;
        e.fault = (resp != 0);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic ordy);
    cycle(tag, 1'b0, 32'h0, 32'h0, 2'b00, ordy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    in_resp   = '0;
    out_ready = 1'b0;

    #22;
    check_val("reset.count",     DW'(count),     32'd0);
    check_val("reset.out_valid", DW'(out_valid), 32'd0);
    check_val("reset.in_ready",  DW'(in_ready),  32'd1);
    check_val("reset.out_fault", DW'(out_fault), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word, no bypass, then pop.
    cycle("single.push", 1'b1, 32'h8000_0000, 32'h0010_0093, 2'b00, 1'b0, 1'b0);
    check_val("single.pc_const",  out_pc,      32'h8000_0000);
    check_val("single.pc4_const", out_pcplus4, 32'h8000_0004);
    check_val("single.cnt_const", DW'(count),  32'd1);
    idle("single.pop", 1'b1);
    idle("single.empty", 1'b0);

    // Fill with 5 attempts; the 5th is refused.
    for (int i = 0; i < 5; i++)
      cycle("fill", 1'b1, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'b00, 1'b0, 1'b0);
    check_val("fill.cnt_const",   DW'(count),    32'd4);
    check_val("fill.ready_const", DW'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // Streaming with wrap-around.
    for (int i = 0; i < 20; i++)
      cycle("stream", 1'b1, 32'h2000_0000 + 32'(i * 4), 32'h0000_0013 + 32'(i << 7), 2'b00, 1'b1, 1'b0);
    check_val("stream.cnt_const", DW'(count), 32'd1);
    idle("stream.tail", 1'b1);

    // Flush while pushing and popping.
    for (int i = 0; i < 3; i++)
      cycle("flush.fill", 1'b1, 32'h3000_0000 + 32'(i * 4), 32'h3300_0000 + 32'(i), 2'b00, 1'b0, 1'b0);
    cycle("flush.hit", 1'b1, 32'h3000_0100, 32'h3300_00FF, 2'b00, 1'b1, 1'b1);
    check_val("flush.cnt_const",   DW'(count),     32'd0);
    check_val("flush.valid_const", DW'(out_valid), 32'd0);
    cycle("flush.push", 1'b1, 32'h3000_0200, 32'h3300_0200, 2'b00, 1'b0, 1'b0);
    check_val("flush.pushed_pc", out_pc, 32'h3000_0200);
    idle("flush.drain", 1'b1);

    // Fault entry followed by an OKAY entry; also PC+4 wrap.
    cycle("fault.push", 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
    cycle("fault.ok",   1'b1, 32'h4000_0000, 32'h0040_0093, 2'b00, 1'b0, 1'b0);
    check_val("fault.inst_const", out_inst,        32'h0000_0013);
    check_val("fault.flag_const", DW'(out_fault),  32'd1);
    check_val("fault.pc4_wrap",   out_pcplus4,     32'h0000_0000);
    idle("fault.pop", 1'b1);
    check_val("fault.next_flag",  DW'(out_fault),  32'd0);
    idle("fault.drain", 1'b1);

    // Asynchronous reset mid-stream with 3 entries held.
    for (int i = 0; i < 3; i++)
      cycle("rst.fill", 1'b1, 32'h5000_0000 + 32'(i * 4), 32'h5500_0000 + 32'(i), 2'b00, 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_val("rst.async.count",     DW'(count),     32'd0);
    check_val("rst.async.out_valid", DW'(out_valid), 32'd0);
    check_val("rst.async.in_ready",  DW'(in_ready),  32'd1);
    exp_q.delete();
    #1 rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle("rst.resume", 1'b1, 32'h6000_0000, 32'h6600_0000, 2'b00, 1'b0, 1'b0);
    idle("rst.resume.drain", 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom,
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_inst_queue.md
# ysyx_23060184_inst_queue

Instruction queue between the fetch stage and decode. It buffers fetched instruction words with their PC, PC+4 and access-fault flag in a small FIFO with valid/ready handshakes on both sides. This decouples instruction-memory latency and burst returns from decode back-pressure. A branch or redirect flush discards every buffered entry in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- DATA_WIDTH, 32: width of PC and instruction.
- ACERR_WIDTH, 2: width of the fetch response code.

Ports (reset is asynchronous, active-high):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  redirect or branch; discard all entries.
- in_valid  input  1  fetch word valid.
- in_ready  output  1  queue can accept a word (`!full`).
- in_pc  input  DATA_WIDTH  PC of the fetched word.
- in_inst  input  DATA_WIDTH  fetched word.
- in_resp  input  ACERR_WIDTH  bus response; nonzero means access fault.
- out_valid  output  1  head entry valid (`!empty`).
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  DATA_WIDTH  head PC.
- out_pcplus4  output  DATA_WIDTH  head PC + 4.
- out_inst  output  DATA_WIDTH  head instruction, or NOP if faulted.
- out_fault  output  1  head entry carried an access fault.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries {pc, inst, fault}, indexed by wptr and rptr. Each pointer has one extra wrap bit, so each is $clog2(DEPTH)+1 bits wide.
  - empty = (wptr == rptr).
  - full = index bits equal and wrap bits differ.
- Push happens when `in_valid && in_ready && !flush`:
  - write {in_pc, in_inst, in_resp != 0} at wptr[idx];
  - increment wptr.
- Pop happens when `out_valid && out_ready && !flush`: increment rptr.
- Push and pop in the same cycle are both performed and count is unchanged. A push while full cannot occur, because in_ready is 0.
- Flush has the highest priority:
  - rptr is set to wptr and count to 0 at the next edge;
  - any same-cycle push and pop are ignored;
  - the storage contents are left unchanged.
- out_pcplus4 = out_pc + 32'd4, modulo 2^DATA_WIDTH (0xFFFFFFFC wraps to 0x0).
- On a faulted head entry: out_inst = 32'h0000_0013 (addi x0,x0,0), and out_fault = 1.
- When out_valid = 0, out_pc, out_inst and out_fault are don't-care. The verification bench must not check them in that state.
- in_ready depends only on state, with no combinational path from out_ready. out_valid depends only on state.

## Timing
- Reset values:
  - wptr = rptr = 0;
  - count = 0, out_valid = 0, in_ready = 1, out_fault = 0.
- Reset asserted mid-operation empties the queue immediately (asynchronous), whatever the handshake state.
- Latency: a word pushed at edge N is at the head with out_valid = 1 after edge N, if the queue was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained. When full and out_ready = 1, in_ready rises in the next cycle (one-cycle bubble on the input side only).
- A flush in cycle N gives out_valid = 0 and count = 0 in cycle N+1. A push is accepted again in cycle N+1.
- Order is strict FIFO. Pointer wrap-around from index DEPTH-1 to 0 is transparent.

## Structure
- The shared defines file holds:
  - `DATA_WIDTH` and `ACERR_WIDTH`;
  - a new `INST_NOP` (32'h0000_0013).
- The response-code check compares against the existing OKAY encoding (0).
- Single module. The entry array and pointer logic are inline, and no sub-module is needed.
- The IFU instantiates this block:
  - Ivalid drives in_valid;
  - in_ready feeds the IFU's downstream-ready input;
  - the Branch redirect drives flush.

## Test plan
- Single word: push pc 0x8000_0000, inst 0x0010_0093 with out_ready = 0.
  - Next cycle: out_valid = 1, out_pc = 0x8000_0000, out_pcplus4 = 0x8000_0004, count = 1.
  - Pop: out_valid = 0.
- Fill and order: push 5 words with out_ready = 0 and DEPTH = 4.
  - in_ready drops after the 4th push and the 5th is not accepted; count = 4.
  - Drain: the 4 PCs appear in push order.
- Streaming: in_valid = out_ready = 1 for 20 cycles with sequential PCs.
  - After the first cycle, one word is popped every cycle with no gaps.
  - count stays at 1, and pointers wrap cleanly past index 3 repeatedly.
- Flush: hold 3 entries, then assert flush in the same cycle as in_valid = 1 and out_ready = 1.
  - Next cycle: count = 0, out_valid = 0, and the flushed-cycle word is absent.
  - Push in the following cycle: accepted.
- Fault: push in_resp = 2'b10 with inst 0xDEAD_BEEF.
  - At the head: out_fault = 1 and out_inst = 0x0000_0013.
  - The following OKAY entry shows out_fault = 0.
- Reset mid-stream: assert rst asynchronously (between clock edges) while count = 3.
  - out_valid = 0, in_ready = 1 and count = 0 before the next edge.
  - Normal operation resumes after rst deasserts.
